// File: rtl/dds_pkg.sv
// Shared widths, mode/state encodings, reset defaults and the clamped step helper
// for the DDS sweep controller.
package dds_pkg;

  localparam int M_W     = 13;
  localparam int A_W     = 11;
  localparam int DWELL_W = 16;

  localparam logic [M_W-1:0] M_DEFAULT     = 13'd164;
  localparam logic [A_W-1:0] A_DEFAULT     = 11'd1000;
  localparam logic [1:0]     SHAPE_DEFAULT = 2'd0;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  // Move cur by step toward bound (up or down) and stop at bound. The extra
  // bit keeps the sum/borrow visible so the result never wraps mod 2^M_W.
  function automatic logic [M_W-1:0] clamp_step(input logic [M_W-1:0] cur,
                                                input logic [M_W-1:0] step,
                                                input logic [M_W-1:0] bound,
                                                input logic           up);
    logic [M_W:0] sum;
    logic [M_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (up)
      return (sum > {1'b0, bound}) ? bound : sum[M_W-1:0];
    else
      return (diff[M_W] || (diff < {1'b0, bound})) ? bound : diff[M_W-1:0];
  endfunction

endpackage

// File: rtl/dds_sweep_controller_step_calc.sv
// Combinational next-tuning-word logic: stepping, clamping at the endpoint being
// approached, and the saw/triangle turn-around behaviour.
module sweep_step_calc
  import dds_pkg::*;
(
  input  logic [M_W-1:0] cur,
  input  logic [M_W-1:0] step,
  input  logic [M_W-1:0] m_start,
  input  logic [M_W-1:0] m_stop,
  input  logic           dir,
  input  logic [1:0]     mode,
  output logic [M_W-1:0] next_m,
  output logic           next_dir,
  output logic           at_end
);

  logic [M_W-1:0] hi;
  logic [M_W-1:0] lo;
  logic [M_W-1:0] target;
  logic [M_W-1:0] other;

  // dir=1 climbs toward the larger endpoint, dir=0 falls toward the smaller one,
  // so the endpoint being approached follows from dir alone.
  always_comb begin
    hi       = (m_start >= m_stop) ? m_start : m_stop;
    lo       = (m_start >= m_stop) ? m_stop  : m_start;
    target   = dir ? hi : lo;
    other    = dir ? lo : hi;
    at_end   = (cur == m_stop);
    next_dir = dir;
    next_m   = clamp_step(cur, step, target, dir);
    if (cur == target) begin
      case (mode)
        MODE_SAW: next_m = m_start;
        MODE_TRI: begin
          next_dir = ~dir;
          next_m   = clamp_step(cur, step, other, ~dir);
        end
        default:  next_m = cur;
      endcase
    end
  end

endmodule

// File: rtl/dds_sweep_controller.sv
// Run-time DDS sequencer: idles on static settings, runs a programmed linear
// tuning-word sweep (single, sawtooth, triangle) with a per-value dwell.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | outputs held, waiting for an accepted start
// ST_DWELL | sweep running, phase_M held for dwell+1 cycles per value
module dds_sweep_controller
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [M_W-1:0]     cfg_m_start,
  input  logic [M_W-1:0]     cfg_m_stop,
  input  logic [M_W-1:0]     cfg_m_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [A_W-1:0]     cfg_amp,
  input  logic [1:0]         cfg_shape,
  output logic [M_W-1:0]     phase_M,
  output logic [A_W-1:0]     signal_A,
  output logic [1:0]         signal_shape,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  logic [0:0]         state;
  logic               dir;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [M_W-1:0]     m_start_q;
  logic [M_W-1:0]     m_stop_q;
  logic [M_W-1:0]     step_q;
  logic [1:0]         mode_q;

  logic [M_W-1:0]     next_m;
  logic               next_dir;
  logic               at_end;

  sweep_step_calc u_step (
    .cur      (phase_M),
    .step     (step_q),
    .m_start  (m_start_q),
    .m_stop   (m_stop_q),
    .dir      (dir),
    .mode     (mode_q),
    .next_m   (next_m),
    .next_dir (next_dir),
    .at_end   (at_end)
  );

  // FSM, dwell counter, latched sweep configuration and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      dir          <= 1'b1;
      dwell_cnt    <= '0;
      dwell_q      <= '0;
      m_start_q    <= '0;
      m_stop_q     <= '0;
      step_q       <= '0;
      mode_q       <= MODE_SINGLE;
      phase_M      <= M_DEFAULT;
      signal_A     <= A_DEFAULT;
      signal_shape <= SHAPE_DEFAULT;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_m_step == '0) begin
              cfg_err <= 1'b1;
            end else begin
              m_start_q    <= cfg_m_start;
              m_stop_q     <= cfg_m_stop;
              step_q       <= cfg_m_step;
              dwell_q      <= cfg_dwell;
              // Encoding 11 is folded into single so the step logic sees three modes.
              mode_q       <= ((cfg_mode == MODE_SAW) || (cfg_mode == MODE_TRI)) ?
                              cfg_mode : MODE_SINGLE;
              dir          <= (cfg_m_start <= cfg_m_stop);
              phase_M      <= cfg_m_start;
              signal_A     <= cfg_amp;
              signal_shape <= cfg_shape;
              busy         <= 1'b1;
              dwell_cnt    <= '0;
              state        <= ST_DWELL;
            end
          end
        end
        default: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            dwell_cnt <= '0;
          end else if (dwell_cnt == dwell_q) begin
            dwell_cnt <= '0;
            if (at_end && (mode_q == MODE_SINGLE)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              phase_M <= next_m;
              dir     <= next_dir;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: directed scenarios plus random
// sweeps compared against a point-list model of the sweep.
`timescale 1ns/1ps
module tb_dds_sweep_controller;
  import dds_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [M_W-1:0]     cfg_m_start = '0;
  logic [M_W-1:0]     cfg_m_stop = '0;
  logic [M_W-1:0]     cfg_m_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [1:0]         cfg_mode = '0;
  logic [A_W-1:0]     cfg_amp = '0;
  logic [1:0]         cfg_shape = '0;
  logic [M_W-1:0]     phase_M;
  logic [A_W-1:0]     signal_A;
  logic [1:0]         signal_shape;
  logic               busy;
  logic               done;
  logic               cfg_err;

  dds_sweep_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_m_start  (cfg_m_start),
    .cfg_m_stop   (cfg_m_stop),
    .cfg_m_step   (cfg_m_step),
    .cfg_dwell    (cfg_dwell),
    .cfg_mode     (cfg_mode),
    .cfg_amp      (cfg_amp),
    .cfg_shape    (cfg_shape),
    .phase_M      (phase_M),
    .signal_A     (signal_A),
    .signal_shape (signal_shape),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  // 1 MHz sample clock.
  always #500 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_phase;
  int last_amp;
  int last_shape;
  int period[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sweep values visited in one period: the start->stop leg, plus for triangle
  // the interior of the stop->start return leg.
  task automatic build(input int ms, input int me, input int st, input int md);
    int cur;
    period.delete();
    cur = ms;
    period.push_back(cur);
    while (cur != me) begin
      if (ms <= me) cur = (cur + st > me) ? me : cur + st;
      else          cur = (cur - st < me) ? me : cur - st;
      period.push_back(cur);
    end
    if (md == 2 && ms != me) begin
      cur = me;
      while (1) begin
        if (ms <= me) cur = (cur - st < ms) ? ms : cur - st;
        else          cur = (cur + st > ms) ? ms : cur + st;
        if (cur == ms) break;
        period.push_back(cur);
      end
    end
  endtask

  task automatic scramble_cfg();
    cfg_m_start = M_W'($urandom);
    cfg_m_stop  = M_W'($urandom);
    cfg_m_step  = M_W'($urandom_range(0, 3));
    cfg_dwell   = DWELL_W'($urandom_range(0, 5));
    cfg_mode    = 2'($urandom);
    cfg_amp     = A_W'($urandom);
    cfg_shape   = 2'($urandom);
  endtask

  // Start a sweep, check every cycle against the model, and end it by done,
  // by abort (kind 0) or by reset (kind 1) at cycle ncyc-1.
  task automatic run_sweep(input int ms, input int me, input int st, input int dw,
                           input int md, input int amp, input int shp,
                           input int ncyc, input int kind);
    int p;
    int idx;
    bit single;
    single = !(md == 1 || md == 2);
    build(ms, me, st, md);
    @(negedge clk);
    cfg_m_start = M_W'(ms);
    cfg_m_stop  = M_W'(me);
    cfg_m_step  = M_W'(st);
    cfg_dwell   = DWELL_W'(dw);
    cfg_mode    = 2'(md);
    cfg_amp     = A_W'(amp);
    cfg_shape   = 2'(shp);
    start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < ncyc; t++) begin
      start = 1'b0;
      idx = t / (dw + 1);
      if (single && idx >= period.size()) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_phase", phase_M, me);
        @(negedge clk);
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        check("idle_phase", phase_M, me);
        last_phase = me; last_amp = amp; last_shape = shp;
        return;
      end
      p = single ? period[idx] : period[idx % period.size()];
      check("phase", phase_M, p);
      check("busy", busy, 1);
      check("no_done", done, 0);
      check("amp", signal_A, amp);
      check("shape", signal_shape, shp);
      if (t == ncyc - 1) begin
        if (kind == 0) abort = 1'b1;
        else           rst = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        rst = 1'b1;
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        if (kind == 0) begin
          check("abort_phase", phase_M, p);
          check("abort_amp", signal_A, amp);
          last_phase = p; last_amp = amp; last_shape = shp;
        end else begin
          check("rst_phase", phase_M, 164);
          check("rst_amp", signal_A, 1000);
          check("rst_shape", signal_shape, 0);
          last_phase = 164; last_amp = 1000; last_shape = 0;
        end
        return;
      end
      scramble_cfg();
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout CHECKS %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int ms, me, st, dw, md, span;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_phase_M", phase_M, 164);
    check("rst_signal_A", signal_A, 1000);
    check("rst_signal_shape", signal_shape, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;
    last_phase = 164; last_amp = 1000; last_shape = 0;

    run_sweep(100, 130, 10, 2, 0, 500, 1, 100, 0);
    run_sweep(100, 75, 10, 0, 0, 700, 2, 100, 0);
    run_sweep(10, 30, 10, 0, 2, 300, 3, 6, 0);
    run_sweep(8180, 8191, 8, 0, 1, 1200, 0, 12, 0);
    run_sweep(42, 42, 5, 1, 0, 250, 1, 20, 0);
    run_sweep(42, 42, 5, 0, 2, 250, 1, 8, 0);
    run_sweep(5, 3, 4, 0, 3, 11, 2, 20, 0);

    // step 0 is rejected with a one-cycle error pulse
    @(negedge clk);
    cfg_m_start = 13'd1; cfg_m_stop = 13'd9; cfg_m_step = '0; cfg_mode = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rej_cfg_err", cfg_err, 1);
    check("rej_busy", busy, 0);
    check("rej_phase", phase_M, last_phase);
    check("rej_amp", signal_A, last_amp);
    check("rej_shape", signal_shape, last_shape);
    @(negedge clk);
    check("rej_err_clear", cfg_err, 0);

    // abort wins over start in the same cycle
    cfg_m_step = 13'd3;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_cfg_err", cfg_err, 0);
    check("sa_phase", phase_M, last_phase);
    @(negedge clk);
    check("sa_busy2", busy, 0);

    // reset in the middle of a sweep
    run_sweep(200, 400, 7, 1, 1, 900, 3, 7, 1);

    for (int i = 0; i < 40; i++) begin
      ms = $urandom_range(0, 8191);
      if ($urandom_range(0, 1) == 1) begin
        span = $urandom_range(0, 80);
        me = ($urandom_range(0, 1) == 1) ? ms + span : ms - span;
        if (me > 8191) me = 8191;
        if (me < 0) me = 0;
        st = $urandom_range(1, 20);
      end else begin
        me = $urandom_range(0, 8191);
        st = $urandom_range(500, 8191);
      end
      dw = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      run_sweep(ms, me, st, dw, md, $urandom_range(0, 2047), $urandom_range(0, 3),
                $urandom_range(1, 200), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
